bm_frame_buf: RTL
=================

// Module: bm_frame_buf
// PURPOSE
//  Parametrised bitmap frame buffer between the JPEG decoder pixel output and the host read path.
//  Stores decoded RGB pixels by (x,y), detects frame completion against full 16-bit image size, clips out-of-range pixels.
//  Optional ping-pong banking lets the host read frame N while frame N+1 is decoded.
//  Sits in the sys_clk domain; the PCI-side CDC is outside this block.
// PARAMETERS
//  XW    8   x address bits; buffer width  = 2**XW pixels
//  YW    8   y address bits; buffer height = 2**YW pixels
//  PW    8   bits per colour component; stored word = 3*PW
// PORTS
//  sys_clk     in   1       system clock, posedge
//  sys_rst     in   1       asynchronous reset, active-low
//  frm_start   in   1       pulse: abort any fill, return to IDLE, clear clip_cnt
//  bm_enable   in   1       pixel write strobe
//  bm_width    in   16      image width in pixels
//  bm_height   in   16      image height in pixels
//  bm_x        in   XW      pixel column
//  bm_y        in   YW      pixel row
//  bm_r/g/b    in   PW each colour components
//  bm_stall    out  1       1 = buffer cannot accept pixels; writes dropped and not counted
//  host_rel    in   1       pulse: host finished reading the current read bank
//  rd_en       in   1       host read request
//  rd_addr     in   XW+YW   {y,x} read address
//  rd_data     out  3*PW    {r,g,b}; valid 1 cycle after rd_en
//  rd_valid    out  1       rd_en delayed by 1 cycle
//  frame_done  out  1       1-cycle pulse when a frame is complete and published to the host
//  frame_cnt   out  16      published frames, wraps 0xFFFF->0
//  clip_cnt    out  16      pixels dropped as out-of-range, saturates at 0xFFFF
//  cfg_err     out  1       1 while width/height is 0 or exceeds 2**XW / 2**YW
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. wr_bank=0, rd_bank=0, host_busy=0.
//  States: IDLE -> FILL on the first accepted bm_enable. FILL -> PUBLISH on the last-pixel write.
//   PUBLISH -> IDLE when publishing is allowed: single bank = always; dual bank = host_busy==0.
//   Otherwise the block holds in PUBLISH with bm_stall=1.
//  Last pixel: {0,x}==clampW-1 and {0,y}==clampH-1, where clampW=min(bm_width,2**XW) and clampH likewise.
//   The compare is 16-bit, zero-extended (no truncated compare).
//  Clipping: x>=bm_width or y>=bm_height -> RAM not written, clip_cnt+1 (saturating). Such a pixel never completes a frame.
//  cfg_err: combinational from bm_width/bm_height.
//   Width or height of 0 -> frame never completes; every pixel is clipped.
//  Publish cycle: frame_done=1, frame_cnt+1, host_busy<=1.
//   Dual bank: rd_bank<=wr_bank, wr_bank<=~wr_bank.
//  host_rel clears host_busy; if it coincides with publish, publish wins and host_busy stays 1.
//  bm_stall=1 in PUBLISH, and for 1 cycle after frm_start.
//  RAM: write on posedge when accepted. Read is synchronous, 1-cycle latency, from rd_bank.
//   Read and write of the same address in the same cycle: read returns the old data.
//  frm_start mid-FILL: partial frame discarded, no frame_done; wr_bank and frame_cnt unchanged.
//  Asynchronous reset mid-frame: state, counters and banks go to reset values; RAM contents undefined.
// CONFIGURATION
//  BM_FB_DBLBUF_EN defined: RAM depth 2*2**(XW+YW), bank bit is the address MSB, ping-pong as above.
//  BM_FB_DBLBUF_EN undefined: single bank, rd_bank==wr_bank==0.
//   The host reads live data; the publish condition ignores host_busy (never stalls).
//   host_busy is still tracked for software.
// STRUCTURE
//  Package bm_fb_pkg: state encoding (IDLE/FILL/PUBLISH), and a SAT16 increment function.
//  Sub-module bm_fb_ram: simple dual-port RAM (1 write, 1 registered read), inferred, depth and width parametrised.
//  Top: FSM, last-pixel and clip compare, counters, bank control.
// TESTING
//  W=H=4, XW=YW=8, raster-write 16 pixels -> frame_done pulses once, 1 cycle after pixel (3,3).
//   frame_cnt=1; rd_addr {2,1} returns the pixel written there after 1 cycle.
//  W=4, write x=5 and y=9 -> clip_cnt=2, RAM unchanged, no frame_done.
//   Then width=0 -> cfg_err=1 and all pixels clipped.
//  DBLBUF: finish frame 0, no host_rel, finish frame 1 -> bm_stall=1 in PUBLISH.
//   host_rel -> publish next cycle, rd_bank=1, frame 0 data still readable before the swap.
//  frm_start after 7 of 16 pixels -> IDLE, no frame_done, frame_cnt unchanged.
//   A full frame afterwards completes normally.
//  host_rel in the same cycle as publish -> host_busy stays 1.
//   The next frame stalls until a second host_rel (DBLBUF).
//  Assert sys_rst low mid-FILL -> all outputs 0 immediately.
//   After release, a fresh 16-pixel frame gives frame_cnt=1.

Source files
------------

// File: rtl/bm_fb_pkg.sv
// Shared types and helpers for the bitmap frame buffer.
package bm_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PUBLISH
  } fb_state_t;

  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bm_fb_if.sv
// Pixel-write, host-read and status bundle of the bitmap frame buffer.
interface bm_fb_if #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int PW = 8
);
  logic              frm_start;
  logic              bm_enable;
  logic [15:0]       bm_width;
  logic [15:0]       bm_height;
  logic [XW-1:0]     bm_x;
  logic [YW-1:0]     bm_y;
  logic [PW-1:0]     bm_r;
  logic [PW-1:0]     bm_g;
  logic [PW-1:0]     bm_b;
  logic              bm_stall;
  logic              host_rel;
  logic              rd_en;
  logic [XW+YW-1:0]  rd_addr;
  logic [3*PW-1:0]   rd_data;
  logic              rd_valid;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic [15:0]       clip_cnt;
  logic              cfg_err;
  logic              host_busy;   // status for software: host still owns the read bank

  modport master (
    output frm_start, bm_enable, bm_width, bm_height, bm_x, bm_y, bm_r, bm_g, bm_b,
           host_rel, rd_en, rd_addr,
    input  bm_stall, rd_data, rd_valid, frame_done, frame_cnt, clip_cnt, cfg_err, host_busy
  );

  modport slave (
    input  frm_start, bm_enable, bm_width, bm_height, bm_x, bm_y, bm_r, bm_g, bm_b,
           host_rel, rd_en, rd_addr,
    output bm_stall, rd_data, rd_valid, frame_done, frame_cnt, clip_cnt, cfg_err, host_busy
  );
endinterface

// File: rtl/bm_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port (read-before-write).
module bm_fb_ram #(
  parameter int AW = 16,
  parameter int DW = 24
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge sys_clk) begin
    if (we) mem[wa] <= wd;
  end

  // Only the output register is reset; array contents are left undefined.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)  rd <= '0;
    else if (re)   rd <= mem[ra];
  end
endmodule

// File: rtl/bm_frame_buf.sv
// Bitmap frame buffer: pixel store by (x,y), frame completion, clipping, host read.
// Define BM_FB_DBLBUF_EN for ping-pong banking between decoder and host.
module bm_frame_buf
  import bm_fb_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int PW = 8
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  bm_fb_if.slave bus
);
  localparam logic [16:0] MAX_W = 17'(2**XW);
  localparam logic [16:0] MAX_H = 17'(2**YW);

  fb_state_t     state, state_nx;
  logic          start_d, host_busy, rd_valid_q;
  logic [15:0]   frame_cnt_q, clip_cnt_q;
  logic          stall, accept, clip, last, wr_px, publish, pub_ok;
  logic [16:0]   w17, h17, x17, y17, clamp_w, clamp_h;
  logic [3*PW-1:0] rd_data;

  // 17-bit compares so a full 2**16 extent still fits without truncation.
  assign w17     = {1'b0, bus.bm_width};
  assign h17     = {1'b0, bus.bm_height};
  assign x17     = 17'(bus.bm_x);
  assign y17     = 17'(bus.bm_y);
  assign clamp_w = (w17 < MAX_W) ? w17 : MAX_W;
  assign clamp_h = (h17 < MAX_H) ? h17 : MAX_H;
  assign clip    = (x17 >= w17) || (y17 >= h17);
  assign last    = (x17 == clamp_w - 17'd1) && (y17 == clamp_h - 17'd1);

  assign stall   = (state == ST_PUBLISH) || start_d;
  assign accept  = bus.bm_enable && !stall && !bus.frm_start;
  assign wr_px   = accept && !clip;

`ifdef BM_FB_DBLBUF_EN
  localparam int AW = XW + YW + 1;
  logic wr_bank, rd_bank;
  logic [AW-1:0] wa, ra;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (publish) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
    end
  end

  assign pub_ok = !host_busy;
  assign wa     = {wr_bank, bus.bm_y, bus.bm_x};
  assign ra     = {rd_bank, bus.rd_addr};
`else
  localparam int AW = XW + YW;
  logic [AW-1:0] wa, ra;

  assign pub_ok = 1'b1;
  assign wa     = {bus.bm_y, bus.bm_x};
  assign ra     = bus.rd_addr;
`endif

  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    if (bus.frm_start) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_FILL: begin
          if (wr_px && last) state_nx = ST_PUBLISH;
          else if (accept)   state_nx = ST_FILL;
        end
        ST_PUBLISH: begin
          if (pub_ok) begin
            publish  = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= ST_IDLE;
      start_d     <= 1'b0;
      host_busy   <= 1'b0;
      rd_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
      clip_cnt_q  <= '0;
    end else begin
      state      <= state_nx;
      start_d    <= bus.frm_start;
      rd_valid_q <= bus.rd_en;
      if (publish) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (bus.frm_start)       clip_cnt_q <= '0;
      else if (accept && clip) clip_cnt_q <= sat16_inc(clip_cnt_q);
      // Publish takes priority over a coincident host release.
      if (publish)           host_busy <= 1'b1;
      else if (bus.host_rel) host_busy <= 1'b0;
    end
  end

  bm_fb_ram #(.AW(AW), .DW(3*PW)) u_ram (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .we      (wr_px),
    .wa      (wa),
    .wd      ({bus.bm_r, bus.bm_g, bus.bm_b}),
    .re      (bus.rd_en),
    .ra      (ra),
    .rd      (rd_data)
  );

  assign bus.bm_stall   = stall;
  assign bus.frame_done = publish;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.clip_cnt   = clip_cnt_q;
  assign bus.host_busy  = host_busy;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data;
  assign bus.cfg_err    = (bus.bm_width == 16'd0) || (bus.bm_height == 16'd0) ||
                          (w17 > MAX_W) || (h17 > MAX_H);
endmodule
